// File: rtl/sync_timing_gen_pkg.sv
// sync_timing_pkg: shared state encoding and default timing constants for sync_timing_gen.
//   Holds the FSM state type, the horizontal defaults used as the generator's
//   parameter defaults, and vertical defaults for a companion vertical instance.
package sync_timing_pkg;
    typedef logic [1:0] state_t;
    // The two-bit encoding is ordered so that +1 walks the phase sequence and
    // wraps from FRONTPORCH back to PULSE.
    localparam state_t PULSE      = 2'd0;
    localparam state_t BACKPORCH  = 2'd1;
    localparam state_t ACTIVE     = 2'd2;
    localparam state_t FRONTPORCH = 2'd3;
    localparam int H_PULSE_CYC = 384;
    localparam int H_BP_CYC    = 192;
    localparam int H_PIX_COUNT = 128;
    localparam int H_PIX_DIV   = 20;
    localparam int H_FP_CYC    = 64;
    localparam int V_PULSE_CYC = 2;
    localparam int V_BP_CYC    = 33;
    localparam int V_PIX_COUNT = 96;
    localparam int V_PIX_DIV   = 1;
    localparam int V_FP_CYC    = 10;
endpackage

// File: rtl/sync_timing_gen_if.sv
// sync_timing_gen_if: signal bundle between a timing generator and its consumer.
//   en         advance enable (consumer -> generator)
//   sync       sync pulse
//   blank      1 outside the active phase
//   pix_addr   current pixel/line index
//   period_end one-cycle strobe on the last enabled front-porch cycle
//   pix_addr_la next-edge pixel address, only with SYNC_TIMING_LOOKAHEAD_EN
interface sync_timing_gen_if #(
    parameter int PIX_W = 7
);
    logic             en;
    logic             sync;
    logic             blank;
    logic [PIX_W-1:0] pix_addr;
    logic             period_end;
`ifdef SYNC_TIMING_LOOKAHEAD_EN
    logic [PIX_W-1:0] pix_addr_la;
`endif
    modport master (
        input  en,
        output sync, blank, pix_addr, period_end
`ifdef SYNC_TIMING_LOOKAHEAD_EN
        , output pix_addr_la
`endif
    );
    modport slave (
        output en,
        input  sync, blank, pix_addr, period_end
`ifdef SYNC_TIMING_LOOKAHEAD_EN
        , input pix_addr_la
`endif
    );
endinterface

// File: rtl/sync_timing_gen_phase_counter.sv
// phase_counter: enable-gated up-counter that clears after reaching a programmable terminal value.
//   clk, reset  clock and synchronous active-high reset
//   en_i        count enable
//   term_i      terminal count (last value before wrap)
//   cnt_o       current count
//   wrap_o      high on the enabled cycle at the terminal count
module phase_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign wrap_o = en_i && (cnt_q == term_i);
    assign cnt_d  = wrap_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    assign cnt_o  = cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sync_timing_gen.sv
// sync_timing_gen: four-phase sync/blanking timing generator with pixel-address counter.
//   clk, reset  clock and synchronous active-high reset
//   bus.en      advance enable; all state holds while low
//   bus.sync    SYNC_POL during PULSE, inverted elsewhere
//   bus.blank   low only during ACTIVE
//   bus.pix_addr current pixel index, 0 outside ACTIVE
//   bus.period_end strobe on the last enabled FRONTPORCH cycle
//   bus.pix_addr_la next-edge pixel address when SYNC_TIMING_LOOKAHEAD_EN is defined
module sync_timing_gen
    import sync_timing_pkg::*;
#(
    parameter int   PULSE_CYC = H_PULSE_CYC,
    parameter int   BP_CYC    = H_BP_CYC,
    parameter int   PIX_COUNT = H_PIX_COUNT,
    parameter int   PIX_DIV   = H_PIX_DIV,
    parameter int   FP_CYC    = H_FP_CYC,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   CNT_W     = 9,
    parameter int   PIX_W     = 7
) (
    input logic               clk,
    input logic               reset,
    sync_timing_gen_if.master bus
);
    state_t           state_q, state_d;
    logic [PIX_W-1:0] pix_q, pix_d, pix_nx;
    logic [CNT_W-1:0] cyc, term;
    logic             wrap, last_pix;
    // In ACTIVE the phase counter acts as the pixel divider.
    assign term = (state_q == PULSE)     ? CNT_W'(PULSE_CYC - 1) :
                  (state_q == BACKPORCH) ? CNT_W'(BP_CYC - 1) :
                  (state_q == ACTIVE)    ? CNT_W'(PIX_DIV - 1) :
                                           CNT_W'(FP_CYC - 1);
    phase_counter #(.W(CNT_W)) u_cyc (
        .clk    (clk),
        .reset  (reset),
        .en_i   (bus.en),
        .term_i (term),
        .cnt_o  (cyc),
        .wrap_o (wrap)
    );
    assign last_pix = (pix_q == PIX_W'(PIX_COUNT - 1));
    // Address after the next enabled edge, independent of en so it can also
    // serve as the look-ahead output.
    assign pix_nx  = (state_q == ACTIVE && cyc == term) ? (last_pix ? '0 : pix_q + 1'b1) : pix_q;
    assign pix_d   = bus.en ? pix_nx : pix_q;
    assign state_d = !wrap ? state_q : (state_q == ACTIVE && !last_pix) ? ACTIVE : state_t'(state_q + 2'd1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PULSE;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
        end
    end
    assign bus.sync       = (state_q == PULSE) ? SYNC_POL : ~SYNC_POL;
    assign bus.blank      = (state_q != ACTIVE);
    assign bus.pix_addr   = pix_q;
    assign bus.period_end = wrap && (state_q == FRONTPORCH);
`ifdef SYNC_TIMING_LOOKAHEAD_EN
    assign bus.pix_addr_la = pix_nx;
`endif
endmodule

// File: doc/sync_timing_gen.md
# sync_timing_gen

Parametrised sync/blanking timing generator for the VGA output path: a four-phase (pulse, back porch, active, front porch) sequencer with a pixel-address counter and a pixel clock divider. It generalises the fixed horizontal sync FSM. All phase lengths, the divider and the sync polarity are parameters. An advance enable lets the same block serve as the horizontal generator (`en` tied high) or the vertical generator (`en` driven by the horizontal `period_end`).

## Interface
- `PULSE_CYC`, default 384: sync pulse length in enabled cycles (≥1).
- `BP_CYC`, default 192: back-porch length in enabled cycles (≥1).
- `PIX_COUNT`, default 128: number of addressable pixels/lines in the active phase (≥1).
- `PIX_DIV`, default 20: enabled cycles per pixel (≥1).
- `FP_CYC`, default 64: front-porch length in enabled cycles (≥1).
- `SYNC_POL`, default 0: level of `sync` during the pulse phase; `~SYNC_POL` elsewhere.
- `CNT_W`, default 9: phase counter width; must hold max(`PULSE_CYC`, `BP_CYC`, `FP_CYC`, `PIX_DIV`) − 1.
- `PIX_W`, default 7: pixel address width; must hold `PIX_COUNT` − 1.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  advance enable; when 0, all state holds.
- `sync`  out  1  sync pulse, polarity per `SYNC_POL`.
- `blank`  out  1  1 outside the active phase (draw black).
- `pix_addr`  out  `PIX_W`  current pixel/line index; 0 outside the active phase.
- `period_end`  out  1  one-cycle strobe on the last enabled cycle of the front porch.

## Operation
- States: PULSE → BACKPORCH → ACTIVE → FRONTPORCH → PULSE. State, phase counter `cyc` and `pix_addr` are registers; all outputs decode from registers only.
- Reset (sampled at a `clk` edge, regardless of `en`): state = PULSE, `cyc` = 0, `pix_addr` = 0. Outputs after reset: `sync` = `SYNC_POL`, `blank` = 1, `pix_addr` = 0, `period_end` = 0.
- PULSE, BACKPORCH, FRONTPORCH: `cyc` counts 0..LEN−1 on enabled cycles. When `cyc` = LEN−1 and `en` = 1, `cyc` clears and the state advances.
- ACTIVE: `cyc` counts 0..`PIX_DIV`−1 as a divider. On wrap, `pix_addr` increments. When `pix_addr` = `PIX_COUNT`−1 and `cyc` = `PIX_DIV`−1 with `en` = 1, the state moves to FRONTPORCH and `pix_addr` clears to 0.
- `blank` = 0 only in ACTIVE. `sync` = `SYNC_POL` only in PULSE.
- `period_end` = `en` AND FRONTPORCH AND `cyc` = `FP_CYC`−1. It is combinational from registers and `en`.
- Period length = `PULSE_CYC` + `BP_CYC` + `PIX_COUNT`·`PIX_DIV` + `FP_CYC` enabled cycles (3200 at defaults).
- An illegal state encoding recovers to PULSE on the next edge with counters cleared.
- Reset asserted mid-phase overrides `en` and all pending transitions.

## Timing
- The first enabled edge after reset release is cycle 0 of PULSE.
- The state change is visible one edge after the final count.
- `pix_addr` changes once every `PIX_DIV` enabled edges. Each value is held for exactly `PIX_DIV` enabled cycles, including `PIX_DIV` = 1.
- With `en` low, outputs are frozen except `period_end`, which is forced to 0.
- Lengths of 1 are legal: the phase lasts a single enabled cycle.

## Configuration
- `SYNC_TIMING_LOOKAHEAD_EN` defined: adds output `pix_addr_la` [`PIX_W`]. It carries the value `pix_addr` will hold after the next enabled edge.
  - It equals 0 during the last BACKPORCH cycle and the last ACTIVE cycle.
  - It aligns addresses for a synchronous-read frame buffer.
- Not defined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- `sync_timing_pkg` holds:
  - the state typedef (PULSE, BACKPORCH, ACTIVE, FRONTPORCH);
  - the default horizontal constants (384/192/128/20/64);
  - vertical defaults for the top-level instance.
- One sub-module, `phase_counter`: a width-parametrised, enable-gated counter with programmable terminal value and a wrap strobe. It is used for `cyc`; `pix_addr` counts inline.

## Test plan
- Defaults, `en` = 1, reset released: `sync` = 0 for cycles 0–383, `blank` = 1 through cycle 575, `pix_addr` = 0 at 576, 1 at 596, and 127 at 3116–3135. `blank` rises at 3136; `period_end` fires at 3199; `sync` = 0 again at 3200.
- `en` toggled 1/0 every cycle: every phase boundary lands at twice the defaults-case cycle index; `period_end` is never high while `en` = 0.
- Reset asserted at cycle 1000 (ACTIVE, `pix_addr` = 21): the next cycle shows `sync` = 0, `blank` = 1, `pix_addr` = 0, and the period restarts from cycle 0.
- Minimal config (all lengths 1, `PIX_COUNT` = 2, `PIX_DIV` = 1, `SYNC_POL` = 1): 5-cycle period; `sync` = 1 only on cycle 0; `pix_addr` = 0, 1 on cycles 2–3.
- H/V chain: horizontal `period_end` drives vertical `en`. Vertical `pix_addr` increments once per 3200 cycles during vertical ACTIVE.
- With `SYNC_TIMING_LOOKAHEAD_EN`: `pix_addr_la` = `pix_addr` + 1 on the last cycle of each pixel, and 0 on cycle 575.
